// File: rtl/frog_pkg.sv
// frog_pkg: shared definitions for the frog game button front end.
//   - key_state_e : per-key debounce FSM states
//   - KEY_* index constants into the 4-bit key vectors {back_2, go_2, back_1, go_1}
//   - default timing constants (50 MHz clock)
//   - cnt_width() : counter width shared by the debounce and repeat counters
//   - gate_step() : step-pulse gating shared by all four keys
package frog_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int NUM_KEYS   = 4;
  localparam int KEY_GO_1   = 0;
  localparam int KEY_BACK_1 = 1;
  localparam int KEY_GO_2   = 2;
  localparam int KEY_BACK_2 = 3;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;     // 1 ms
  localparam int DEF_REPEAT_DELAY    = 25000000;  // 0.5 s
  localparam int DEF_REPEAT_RATE     = 10000000;  // 0.2 s

  // Width of a counter able to hold the largest of the three timing values.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction

  // A step fires only for an unheld strobe whose partner key is neither
  // already down nor strobing in the same cycle.
  function automatic logic gate_step(input logic strobe, input logic hold_game,
                                     input logic opp_level, input logic opp_strobe);
    return strobe & ~hold_game & ~opp_level & ~opp_strobe;
  endfunction

endpackage

// File: rtl/frog_key.sv
// frog_key: synchroniser + debounce FSM for one raw push-button.
// Optional feature macro: FROG_KEYPAD_REPEAT_EN (auto-repeat strobes while held).
// Ports:
//   clk    in  clock
//   rst    in  synchronous active-high reset
//   raw    in  raw button, asynchronous to clk
//   level  out debounced level (registered)
//   strobe out one-cycle press strobe, decoded from registered state; the
//              parent registers it, so it lines up with the level rise
module frog_key
  import frog_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic strobe
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_FULL  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       sync1_r, sync2_r;
  key_state_e state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic       level_r, level_s;
  logic       press_strobe_s;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce FSM state, counter and level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      level_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      level_r <= level_s;
    end
  end

  // Next-state logic. The press side accepts one edge after the last
  // counted sample so the registered strobe and the level rise coincide;
  // the release side accepts on the last counted sample itself.
  always_comb begin
    state_s        = state_r;
    cnt_s          = cnt_r;
    level_s        = level_r;
    press_strobe_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sync2_r) begin
          state_s = PRESS_WAIT;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s   = CNT_ZERO;
        end
      end
      PRESS_WAIT: begin
        if (cnt_r == DB_FULL) begin
          state_s        = HELD;
          level_s        = 1'b1;
          cnt_s          = CNT_ZERO;
          press_strobe_s = 1'b1;
        end else if (sync2_r) begin
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end
      end
      HELD: begin
        if (!sync2_r) begin
          state_s = RELEASE_WAIT;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s   = CNT_ZERO;
        end
      end
      RELEASE_WAIT: begin
        if (sync2_r) begin
          state_s = HELD;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == DB_LAST) begin
          state_s = IDLE;
          level_s = 1'b0;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        level_s = 1'b0;
      end
    endcase
  end

  assign level = level_r;

`ifdef FROG_KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_DELAY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] REP_RATE  = CNT_W'(REPEAT_RATE);

  logic [CNT_W-1:0] rep_cnt_r, rep_cnt_s;
  logic             rep_armed_r, rep_armed_s;   // first repeat already issued
  logic             rep_strobe_s;

  // Repeat timer: counts cycles since the last strobe, only while HELD, so
  // a bounce through RELEASE_WAIT freezes it without restarting it.
  always_comb begin
    rep_cnt_s    = rep_cnt_r;
    rep_armed_s  = rep_armed_r;
    rep_strobe_s = 1'b0;
    if (press_strobe_s) begin
      rep_cnt_s   = CNT_ONE;
      rep_armed_s = 1'b0;
    end else if (state_r == HELD) begin
      if (rep_cnt_r == (rep_armed_r ? REP_RATE : REP_DELAY)) begin
        rep_strobe_s = 1'b1;
        rep_cnt_s    = CNT_ONE;
        rep_armed_s  = 1'b1;
      end else begin
        rep_cnt_s = rep_cnt_r + CNT_ONE;
      end
    end else begin
      rep_cnt_s = rep_cnt_r;
    end
  end

  // Repeat timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_r   <= CNT_ZERO;
      rep_armed_r <= 1'b0;
    end else begin
      rep_cnt_r   <= rep_cnt_s;
      rep_armed_r <= rep_armed_s;
    end
  end

  assign strobe = press_strobe_s | rep_strobe_s;
`else
  assign strobe = press_strobe_s;
`endif

endmodule

// File: rtl/frog_keypad.sv
// frog_keypad: button front end for the two-player frog game.
// Debounces four raw buttons and emits registered one-cycle step pulses,
// suppressing go+back conflicts within a player and all pulses during hold.
// Optional feature macro: FROG_KEYPAD_REPEAT_EN (auto-repeat while held).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   btn_go_1/back_1/go_2/back_2   raw buttons, active-high, asynchronous
//   hold                          suppress all step pulses (strobes discarded)
//   go_1/back_1/go_2/back_2       registered one-cycle step pulses
//   btn_level[3:0]                debounced levels {back_2, go_2, back_1, go_1}
module frog_keypad
  import frog_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_go_1,
  input  logic       btn_back_1,
  input  logic       btn_go_2,
  input  logic       btn_back_2,
  input  logic       hold,
  output logic       go_1,
  output logic       back_1,
  output logic       go_2,
  output logic       back_2,
  output logic [3:0] btn_level
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);

  logic [NUM_KEYS-1:0] raw_s;
  logic [NUM_KEYS-1:0] key_strobe_s;
  logic [NUM_KEYS-1:0] key_level_s;
  logic [NUM_KEYS-1:0] pulse_s;
  logic [NUM_KEYS-1:0] pulse_r;

  assign raw_s[KEY_GO_1]   = btn_go_1;
  assign raw_s[KEY_BACK_1] = btn_back_1;
  assign raw_s[KEY_GO_2]   = btn_go_2;
  assign raw_s[KEY_BACK_2] = btn_back_2;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    frog_key #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .CNT_W           (CNT_W)
    ) u_key (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw_s[g]),
      .level  (key_level_s[g]),
      .strobe (key_strobe_s[g])
    );
  end

  // Step gating: hold and same-player conflicts kill the strobe outright.
  always_comb begin
    pulse_s             = {NUM_KEYS{1'b0}};
    pulse_s[KEY_GO_1]   = gate_step(key_strobe_s[KEY_GO_1], hold,
                                    key_level_s[KEY_BACK_1], key_strobe_s[KEY_BACK_1]);
    pulse_s[KEY_BACK_1] = gate_step(key_strobe_s[KEY_BACK_1], hold,
                                    key_level_s[KEY_GO_1], key_strobe_s[KEY_GO_1]);
    pulse_s[KEY_GO_2]   = gate_step(key_strobe_s[KEY_GO_2], hold,
                                    key_level_s[KEY_BACK_2], key_strobe_s[KEY_BACK_2]);
    pulse_s[KEY_BACK_2] = gate_step(key_strobe_s[KEY_BACK_2], hold,
                                    key_level_s[KEY_GO_2], key_strobe_s[KEY_GO_2]);
  end

  // Step pulse output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_r <= {NUM_KEYS{1'b0}};
    end else begin
      pulse_r <= pulse_s;
    end
  end

  assign go_1      = pulse_r[KEY_GO_1];
  assign back_1    = pulse_r[KEY_BACK_1];
  assign go_2      = pulse_r[KEY_GO_2];
  assign back_2    = pulse_r[KEY_BACK_2];
  assign btn_level = key_level_s;

endmodule

// File: doc/frog_keypad.md
# frog_keypad

Button front end for the two-player frog game. Takes the four raw push-buttons (go/back per player), synchronises and debounces them, and emits the single-cycle `go_1`/`back_1`/`go_2`/`back_2` step pulses that the frog movement logic consumes. It also suppresses conflicting go+back presses and freezes all step pulses while the game is held (win or reset display).

## Interface
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive stable synchronised samples required to accept a press or a release (1 ms at 50 MHz); minimum 2.
- `REPEAT_DELAY`, default 25000000: held-cycles from the first pulse to the first auto-repeat pulse.
- `REPEAT_RATE`, default 10000000: cycles between subsequent auto-repeat pulses.
- `clk  in  1`: single clock for the whole block.
- `rst  in  1`: synchronous, active-high reset.
- `btn_go_1, btn_back_1, btn_go_2, btn_back_2  in  1 each`: raw buttons, active-high, asynchronous to `clk`.
- `hold  in  1`: when high, all step pulses are suppressed.
- `go_1, back_1, go_2, back_2  out  1 each`: registered step pulses, one cycle wide.
- `btn_level  out  4`: debounced levels {back_2, go_2, back_1, go_1}.

## Operation
- Each raw input passes through a 2-flop synchroniser, then through an independent per-key FSM with one counter (width `$clog2` of the largest parameter, plus 1).
- FSM states:
  - **IDLE**: level 0. A synchronised 1 loads the counter and moves to PRESS_WAIT.
  - **PRESS_WAIT**: the counter increments on each synchronised 1. A 0 returns to IDLE and clears the counter. On reaching `DEBOUNCE_CYCLES` the FSM moves to HELD, the level goes to 1, and the key raises its press strobe.
  - **HELD**: a synchronised 0 moves to RELEASE_WAIT. With repeat enabled, the repeat counter runs here.
  - **RELEASE_WAIT**: the symmetric debounce on 0. A 1 returns to HELD; the repeat counter is not restarted and does not advance while in RELEASE_WAIT. On completion the FSM moves to IDLE and the level goes to 0.
- Step pulse output: `go_x`/`back_x` equals that key's strobe AND NOT `hold` AND NOT (the opposite key of the same player has level 1), registered.
- Go and back for the same player never pulse in the same cycle. If both strobe together, neither pulses.
- Strobes arriving while `hold` is high are discarded, not deferred. Keys keep tracking their levels during `hold`.
- Players are fully independent: simultaneous pulses on `go_1` and `go_2` are legal.
- Reset mid-press: all FSMs go to IDLE, counters and synchronisers clear. A button still held after reset is treated as a fresh press.

## Timing
- Reset values: all pulses 0, `btn_level` 4'b0000, all FSMs IDLE, synchronisers 0.
- Press latency: a raw rise sampled at edge k gives a pulse high during the cycle after edge k+2+`DEBOUNCE_CYCLES`. This is a fixed latency of `DEBOUNCE_CYCLES`+3 edges.
- `btn_level` rises on the same edge as the pulse.
- Release latency is `DEBOUNCE_CYCLES`+2 edges to `btn_level` falling. No pulse is generated on release.
- A glitch shorter than `DEBOUNCE_CYCLES` produces no pulse and no level change.
- Pulse width is exactly one cycle. Without repeat, at most one pulse is produced per accepted press.

## Configuration
- `FROG_KEYPAD_REPEAT_EN` defined:
  - In HELD, the key strobes again after `REPEAT_DELAY` cycles from the first strobe, then every `REPEAT_RATE` cycles while held.
  - Repeat strobes obey the same `hold` and conflict gating as the first strobe.
- `FROG_KEYPAD_REPEAT_EN` undefined:
  - The repeat counter and logic are absent.
  - HELD waits only for release; exactly one pulse is produced per press.

## Structure
- Shared package `frog_pkg`:
  - key state enum {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT};
  - key index constants KEY_GO_1=0, KEY_BACK_1=1, KEY_GO_2=2, KEY_BACK_2=3;
  - default timing constants.
- One natural sub-module, `frog_key`: synchroniser, FSM, counter(s) and strobe for a single button, instantiated four times. The top level does gating, conflict suppression and output registers.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_RATE`=3.
- Clean press: `btn_go_1` is 1 from edge 0 for 20 cycles. `go_1` is high for exactly one cycle after edge 7, `btn_level[0]` is 1 from edge 7, and no other output toggles.
- Bounce: `btn_back_2` pattern 1,1,0,1,1,1,0, then low. No pulse on `back_2`; `btn_level[3]` stays 0.
- Conflict: `btn_go_1` and `btn_back_1` rise on the same edge. Neither `go_1` nor `back_1` pulses; `btn_level[1:0]`=2'b11.
- Hold: `hold`=1, then press `btn_go_2`. No `go_2` pulse. Drop `hold` while the key is still held: still no pulse, since the strobe was discarded.
- Repeat (macro defined): hold `btn_go_1` for 30 cycles. Pulses occur after edges 7, 17, 20, 23, 26, 29. With the macro undefined, only the pulse after edge 7 occurs.
- Reset mid-press: assert `rst` at edge 5 of a press and keep the button high. All outputs are 0 during reset; the pulse comes `DEBOUNCE_CYCLES`+3 edges after `rst` deasserts.
